// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;

  // Clock cycles per oversampling tick. Clamped to 1 so a very slow
  // system clock still produces a usable (if inaccurate) tick.
  function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                               input int unsigned baud,
                                               input int unsigned ovs);
    int unsigned d;
    d = clk_hz / (baud * ovs);
    return (d == 0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-side valid/ready handshake. The receiver is the master.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with a registered head word and head-valid flag.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]    count, count_n;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] head_n;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign rd_ptr_n = do_pop ? rd_ptr + AW'(1) : rd_ptr;

  // Next occupancy and next head word. The only time the next head slot is
  // being written this cycle is when the FIFO drains to empty as the word
  // arrives, so bypass the write data in that case.
  always_comb begin
    count_n = count;
    if (do_push && !do_pop)
      count_n = count + CW'(1);
    else if (!do_push && do_pop)
      count_n = count - CW'(1);
    head_n = (do_push && (wr_ptr == rd_ptr_n)) ? push_data : mem[rd_ptr_n];
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_n;
      count      <= count_n;
      head_valid <= (count_n != '0);
      if (count_n != '0)
        head <= head_n;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled frame recovery, run-time baud
// select, receive FIFO on a valid/ready port, per-frame error pulses.
// Optional parity support is compiled in with UART_RX_PARITY_EN.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            serial_in,
  input  logic [1:0]      S,
`ifdef UART_RX_PARITY_EN
  input  logic            parity_odd,
`endif
  uart_rx_param_if.master rx_if,
  output logic            rx_busy,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun
);

  localparam int unsigned DIV_9600   = baud_divisor(CLK_FREQ_HZ, BAUD_9600,   OVERSAMPLE);
  localparam int unsigned DIV_19200  = baud_divisor(CLK_FREQ_HZ, BAUD_19200,  OVERSAMPLE);
  localparam int unsigned DIV_57600  = baud_divisor(CLK_FREQ_HZ, BAUD_57600,  OVERSAMPLE);
  localparam int unsigned DIV_115200 = baud_divisor(CLK_FREQ_HZ, BAUD_115200, OVERSAMPLE);

  localparam int unsigned DIVW = $clog2(DIV_9600 + 1);
  localparam int unsigned TW   = $clog2(OVERSAMPLE);
  localparam int unsigned BW   = $clog2(DATA_BITS);

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 sync1, sync2, line_d;
  logic                 armed;
  logic [DIVW-1:0]      div_sel, div_lat, div_cnt;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick, sample_pt;
  logic                 push;
  logic [DATA_BITS-1:0] push_data;
  logic                 fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  // Baud select to divisor lookup.
  always_comb begin
    div_sel = DIVW'(DIV_9600);
    case (S)
      2'b00:   div_sel = DIVW'(DIV_9600);
      2'b01:   div_sel = DIVW'(DIV_19200);
      2'b10:   div_sel = DIVW'(DIV_57600);
      default: div_sel = DIVW'(DIV_115200);
    endcase
  end

  assign tick      = (div_cnt >= div_lat - DIVW'(1));
  assign sample_pt = tick && ((state == START) ? (tick_cnt == HALF_LAST)
                                               : (tick_cnt == BIT_LAST));

  // Two-flop synchroniser plus edge-detect register, idle high.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_d <= 1'b1;
    end else begin
      sync1  <= serial_in;
      sync2  <= sync1;
      line_d <= sync2;
    end
  end

  // Frame FSM with baud/tick counters and registered status outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= IDLE;
      armed     <= 1'b1;
      div_lat   <= '0;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      push_data <= '0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (state != IDLE) begin
        if (tick) begin
          div_cnt  <= '0;
          tick_cnt <= sample_pt ? '0 : tick_cnt + TW'(1);
        end else begin
          div_cnt <= div_cnt + DIVW'(1);
        end
      end

      case (state)
        IDLE: begin
          // After a frame error the line may sit low (break); only a fresh
          // high-to-low transition after seeing the line high starts a frame.
          if (sync2)
            armed <= 1'b1;
          if (armed && line_d && !sync2) begin
            state    <= START;
            div_lat  <= div_sel;
            div_cnt  <= '0;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (sample_pt) begin
            if (!sync2) begin
              state   <= DATA;
              rx_busy <= 1'b1;
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              par_bad <= 1'b0;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (sample_pt) begin
            shreg   <= {sync2, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + BW'(1);
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample_pt) begin
            par_bad <= ^{shreg, sync2, parity_odd};
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (sample_pt) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
            if (!sync2) begin
              frame_err <= 1'b1;
              armed     <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_bad) begin
              parity_err <= 1'b1;
            end
`endif
            else begin
              push      <= 1'b1;
              push_data <= shreg;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Overrun: a good word meets a full FIFO that is not being popped.
  always_ff @(posedge clk_in) begin
    if (reset)
      overrun <= 1'b0;
    else
      overrun <= push && fifo_full && !(rx_if.rx_ready && !fifo_empty);
  end

  uart_rx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (rx_if.rx_ready),
    .head      (rx_if.rx_data),
    .head_valid(rx_if.rx_valid),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: frame-level reference model with a word
// queue and error counters; random frames at several baud rates.
module tb_uart_rx_param;

  localparam int unsigned CLK_HZ = 3_686_400;
  localparam int unsigned DB     = 8;
  localparam int unsigned OVS    = 16;
  localparam int unsigned DEPTH  = 4;

  logic       clk_in    = 1'b0;
  logic       reset     = 1'b1;
  logic       serial_in = 1'b1;
  logic [1:0] S         = 2'b00;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd = 1'b0;
`endif
  logic       rx_busy, frame_err, parity_err, overrun;

  uart_rx_param_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx_param #(
    .CLK_FREQ_HZ(CLK_HZ),
    .DATA_BITS  (DB),
    .OVERSAMPLE (OVS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .serial_in (serial_in),
    .S         (S),
`ifdef UART_RX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .rx_if     (rx_if),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [DB-1:0] exp_q[$];
  int exp_fe = 0, exp_pe = 0, exp_ov = 0;

  // Observed pulse activity.
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, wide_cnt = 0, busy_cycles = 0;
  logic fe_q = 1'b0, pe_q = 1'b0, ov_q = 1'b0;

  always @(negedge clk_in) begin
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overrun)    ov_cnt++;
    if ((frame_err && fe_q) || (parity_err && pe_q) || (overrun && ov_q))
      wide_cnt++;
    if (rx_busy) busy_cycles++;
    fe_q = frame_err;
    pe_q = parity_err;
    ov_q = overrun;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic int bit_cycles(input logic [1:0] sel);
    int unsigned baud;
    case (sel)
      2'b00:   baud = 9600;
      2'b01:   baud = 19200;
      2'b10:   baud = 57600;
      default: baud = 115200;
    endcase
    return int'((CLK_HZ / (baud * OVS)) * OVS);
  endfunction

  task automatic drive(input logic v, input int n);
    serial_in = v;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_val,
                            input logic par_flip, input int gap, input logic scramble);
    int   bc;
    logic bad_par;
    bc      = bit_cycles(S);
    bad_par = 1'b0;
    drive(1'b0, bc);
    if (scramble) S = 2'($urandom);
    for (int i = 0; i < int'(DB); i++) drive(d[i], bc);
`ifdef UART_RX_PARITY_EN
    drive(^d ^ parity_odd ^ par_flip, bc);
    bad_par = par_flip;
`endif
    drive(stop_val, bc);
    drive(1'b1, gap);
    serial_in = 1'b1;
    if (!stop_val)                  exp_fe++;
    else if (bad_par)               exp_pe++;
    else if (exp_q.size() < DEPTH)  exp_q.push_back(d);
    else                            exp_ov++;
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_frame_err"},  fe_cnt, exp_fe);
    check_eq({tag, "_parity_err"}, pe_cnt, exp_pe);
    check_eq({tag, "_overrun"},    ov_cnt, exp_ov);
    check_eq({tag, "_pulse_width"}, wide_cnt, 0);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    rx_if.rx_ready = 1'b1;
    while (guard < 64) begin
      @(negedge clk_in);
      if (rx_if.rx_valid) begin
        if (exp_q.size() == 0) check_eq({tag, "_extra_word"}, rx_if.rx_valid, 0);
        else                   check_eq({tag, "_pop"}, rx_if.rx_data, exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        break;
      end
      @(posedge clk_in);
      #1;
      guard++;
    end
    @(posedge clk_in);
    #1;
    rx_if.rx_ready = 1'b0;
    check_eq({tag, "_words_left"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk_in);
    check_eq({tag, "_valid_after"}, rx_if.rx_valid, 0);
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    int b0;
    rx_if.rx_ready = 1'b0;

    // Reset state.
    reset = 1'b1;
    repeat (10) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    check_eq("rst_rx_data",    rx_if.rx_data, 0);
    check_eq("rst_rx_valid",   rx_if.rx_valid, 0);
    check_eq("rst_rx_busy",    rx_busy, 0);
    check_eq("rst_frame_err",  frame_err, 0);
    check_eq("rst_parity_err", parity_err, 0);
    check_eq("rst_overrun",    overrun, 0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    drive(1'b1, 20);

    // Single frame at 19200.
    S = 2'b01;
    send_frame(8'h50, 1'b1, 1'b0, 4, 1'b0);
    @(negedge clk_in);
    check_eq("t1_valid", rx_if.rx_valid, 1);
    check_eq("t1_data",  rx_if.rx_data, 8'h50);
    check_eq("t1_busy",  rx_busy, 0);
    @(posedge clk_in);
    #1;
    check_flags("t1");
    drain("t1");

    // Back-to-back frames at 115200, then ordered drain.
    S = 2'b11;
    send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 2, 1'b0);
    check_flags("t2");
    drain("t2");

    // Five frames into a four-entry FIFO.
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1, 1'b0, 2, 1'b0);
    check_eq("t3_overrun_once", ov_cnt, 1);
    check_flags("t3");
    drain("t3");

    // Framing error followed by a break, then a good frame.
    bc = bit_cycles(S);
    send_frame(8'h81, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 3 * bc);
    drive(1'b1, 40);
    send_frame(8'h42, 1'b1, 1'b0, 4, 1'b0);
    check_flags("t4");
    drain("t4");

    // Glitch shorter than half a bit.
    b0 = busy_cycles;
    drive(1'b0, 3 * (bc / int'(OVS)));
    drive(1'b1, 80);
    check_eq("t5_busy_cycles", busy_cycles, b0);
    check_eq("t5_valid", rx_if.rx_valid, 0);
    check_flags("t5");

    // Reset in the middle of the data bits.
    S  = 2'b10;
    bc = bit_cycles(S);
    drive(1'b0, bc);
    drive(1'b1, bc);
    drive(1'b0, bc / 2);
    @(negedge clk_in);
    check_eq("t6_busy_mid", rx_busy, 1);
    @(posedge clk_in);
    #1;
    reset     = 1'b1;
    serial_in = 1'b1;
    @(posedge clk_in);
    #1;
    @(negedge clk_in);
    check_eq("t6_busy_rst",  rx_busy, 0);
    check_eq("t6_valid_rst", rx_if.rx_valid, 0);
    check_eq("t6_data_rst",  rx_if.rx_data, 0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    drive(1'b1, 20);
    send_frame(8'h11, 1'b1, 1'b0, 4, 1'b0);
    check_flags("t6");
    drain("t6");

    // Slowest rate.
    S = 2'b00;
    send_frame(8'($urandom), 1'b1, 1'b0, 4, 1'b0);
    check_flags("t7");
    drain("t7");

`ifdef UART_RX_PARITY_EN
    // Even parity: wrong parity bit, then correct.
    S = 2'b11;
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 4, 1'b0);
    check_eq("t8_valid_after_bad", rx_if.rx_valid, 0);
    send_frame(8'h07, 1'b1, 1'b0, 4, 1'b0);
    check_flags("t8");
    drain("t8");
`endif

    // Randomised frames, mid-frame baud changes and occasional drains.
    for (int n = 0; n < 24; n++) begin
      logic stop_v;
      logic flip;
      int   gap;
      case ($urandom_range(0, 4))
        0:       S = 2'b01;
        1, 2:    S = 2'b10;
        default: S = 2'b11;
      endcase
`ifdef UART_RX_PARITY_EN
      parity_odd = 1'($urandom);
`endif
      stop_v = ($urandom_range(0, 9) != 0);
      flip   = ($urandom_range(0, 5) == 0);
      gap    = $urandom_range(0, 12);
      if (!stop_v && gap < 8) gap = 8;
      send_frame(8'($urandom), stop_v, flip, gap, ($urandom_range(0, 3) == 0));
      check_flags("rnd");
      if ($urandom_range(0, 2) == 0) drain("rnd");
    end
    drain("rnd_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
